// File: rtl/cache_types.sv
// Shared cache types for the L1/L2 interconnect.
//
// Contents:
//   LINE_W / ADDR_W  - cacheline and address widths
//   OFFSET_W         - byte-offset bits inside a line (cleared on the L2 side)
//   arb_state_t      - L2 arbiter FSM states
//   arb_owner_t      - L2 arbiter grant owner
//   line_align()     - clears the byte offset of an address
package cache_types;

   localparam int unsigned LINE_W   = 256;
   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned OFFSET_W = 5;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } arb_state_t;

   typedef enum logic {
      OWN_I,
      OWN_D
   } arb_owner_t;

   function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
   endfunction

endpackage

// File: rtl/l2_arb_pick.sv
// Combinational grant decision for the L2 arbiter.
//
// Configuration macro: L2_ARB_RR_EN
//   defined   - round-robin: with both requesters valid, grant the one that
//               did not own the previous grant
//   undefined - fixed priority, D-cache before I-cache (I may starve)
//
// Ports:
//   i_valid    in  I-cache request valid
//   d_valid    in  D-cache request valid (already qualified as read XOR write)
//   last_owner in  owner of the most recent grant
//   gnt_valid  out a grant can be issued this cycle
//   gnt_owner  out selected owner (meaningful only when gnt_valid)
module l2_arb_pick
   import cache_types::*;
(
   input  logic       i_valid,
   input  logic       d_valid,
   input  arb_owner_t last_owner,
   output logic       gnt_valid,
   output arb_owner_t gnt_owner
);

   assign gnt_valid = i_valid | d_valid;

`ifdef L2_ARB_RR_EN
   always_comb begin
      gnt_owner = OWN_D;
      if (i_valid && d_valid) begin
         gnt_owner = (last_owner == OWN_D) ? OWN_I : OWN_D;
      end else if (i_valid) begin
         gnt_owner = OWN_I;
      end
   end
`else
   // Fixed priority never looks at history.
   logic unused_last_owner;
   assign unused_last_owner = last_owner;

   always_comb begin
      gnt_owner = OWN_D;
      if (!d_valid && i_valid) begin
         gnt_owner = OWN_I;
      end
   end
`endif

endmodule

// File: rtl/l2_arbiter.sv
// Two-port arbiter sharing the unified L2 between the L1 I-cache and D-cache.
// One requester is granted at a time; its command is latched and driven to
// the L2 from registers, and the L2 line/response is returned to the owner.
//
// Configuration macro: L2_ARB_RR_EN (round-robin vs fixed D-first priority),
// applied inside l2_arb_pick.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   i_read, i_address   I-cache line read request
//   i_rdata, i_resp     line data / one-cycle completion to I-cache
//   d_read, d_write     D-cache line read / write request (both high = illegal)
//   d_address, d_wdata  D-cache address / writeback line
//   d_rdata, d_resp     line data / one-cycle completion to D-cache
//   l2_read, l2_write   registered command to L2 (high only while BUSY)
//   l2_address          line-aligned L2 address (0 outside BUSY)
//   l2_wdata            L2 write line (0 outside BUSY)
//   l2_rdata, l2_resp   L2 read line / completion (may arrive in first cycle)
module l2_arbiter
   import cache_types::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              l2_read,
   output logic              l2_write,
   output logic [ADDR_W-1:0] l2_address,
   output logic [LINE_W-1:0] l2_wdata,
   input  logic [LINE_W-1:0] l2_rdata,
   input  logic              l2_resp
);

   arb_state_t        state_q, state_d;
   arb_owner_t        owner_q, owner_d;
   logic              l2_read_q, l2_read_d;
   logic              l2_write_q, l2_write_d;
   logic [ADDR_W-1:0] l2_address_q, l2_address_d;
   logic [LINE_W-1:0] l2_wdata_q, l2_wdata_d;
   logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
   logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
   logic              i_resp_q, i_resp_d;
   logic              d_resp_q, d_resp_d;

   logic       d_valid;
   logic       gnt_valid;
   arb_owner_t gnt_owner;

   // Read and write together is malformed and simply never becomes valid.
   assign d_valid = d_read ^ d_write;

   l2_arb_pick u_pick (
      .i_valid    (i_read),
      .d_valid    (d_valid),
      .last_owner (owner_q),
      .gnt_valid  (gnt_valid),
      .gnt_owner  (gnt_owner)
   );

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      l2_read_d    = l2_read_q;
      l2_write_d   = l2_write_q;
      l2_address_d = l2_address_q;
      l2_wdata_d   = l2_wdata_q;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      i_resp_d     = 1'b0;
      d_resp_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               state_d = BUSY;
               owner_d = gnt_owner;
               if (gnt_owner == OWN_D) begin
                  l2_read_d    = d_read;
                  l2_write_d   = d_write;
                  l2_address_d = line_align(d_address);
                  l2_wdata_d   = d_write ? d_wdata : '0;
               end else begin
                  l2_read_d    = 1'b1;
                  l2_write_d   = 1'b0;
                  l2_address_d = line_align(i_address);
                  l2_wdata_d   = '0;
               end
            end
         end

         BUSY: begin
            if (l2_resp) begin
               state_d      = DONE;
               l2_read_d    = 1'b0;
               l2_write_d   = 1'b0;
               l2_address_d = '0;
               l2_wdata_d   = '0;
               if (owner_q == OWN_I) begin
                  i_rdata_d = l2_rdata;
                  i_resp_d  = 1'b1;
               end else begin
                  d_rdata_d = l2_rdata;
                  d_resp_d  = 1'b1;
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d      = IDLE;
            l2_read_d    = 1'b0;
            l2_write_d   = 1'b0;
            l2_address_d = '0;
            l2_wdata_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         owner_q      <= OWN_D;
         l2_read_q    <= 1'b0;
         l2_write_q   <= 1'b0;
         l2_address_q <= '0;
         l2_wdata_q   <= '0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
         i_resp_q     <= 1'b0;
         d_resp_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         l2_read_q    <= l2_read_d;
         l2_write_q   <= l2_write_d;
         l2_address_q <= l2_address_d;
         l2_wdata_q   <= l2_wdata_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
         i_resp_q     <= i_resp_d;
         d_resp_q     <= d_resp_d;
      end
   end

   assign l2_read    = l2_read_q;
   assign l2_write   = l2_write_q;
   assign l2_address = l2_address_q;
   assign l2_wdata   = l2_wdata_q;
   assign i_rdata    = i_rdata_q;
   assign d_rdata    = d_rdata_q;
   assign i_resp     = i_resp_q;
   assign d_resp     = d_resp_q;

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: directed scenarios with literal
// expectations, then randomized requester/L2 traffic checked every cycle
// against a transaction-level model of the arbiter.
module tb_l2_arbiter;

   logic         clk;
   logic         rst;
   logic         i_read;
   logic [31:0]  i_address;
   logic [255:0] i_rdata;
   logic         i_resp;
   logic         d_read;
   logic         d_write;
   logic [31:0]  d_address;
   logic [255:0] d_wdata;
   logic [255:0] d_rdata;
   logic         d_resp;
   logic         l2_read;
   logic         l2_write;
   logic [31:0]  l2_address;
   logic [255:0] l2_wdata;
   logic [255:0] l2_rdata;
   logic         l2_resp;

   int errors = 0;
   int checks = 0;

   int           force_lat = 0;
   bit           use_fixed = 0;
   logic [255:0] fixed_rdata = '0;

   l2_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .i_read     (i_read),
      .i_address  (i_address),
      .i_rdata    (i_rdata),
      .i_resp     (i_resp),
      .d_read     (d_read),
      .d_write    (d_write),
      .d_address  (d_address),
      .d_wdata    (d_wdata),
      .d_rdata    (d_rdata),
      .d_resp     (d_resp),
      .l2_read    (l2_read),
      .l2_write   (l2_write),
      .l2_address (l2_address),
      .l2_wdata   (l2_wdata),
      .l2_rdata   (l2_rdata),
      .l2_resp    (l2_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [255:0] rand256();
      return {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic chk1(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic chk256(input string name, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model: one outstanding transaction, tracked as "in flight"
   // and "completing", with the grant rule from the arbitration policy.
   // ---------------------------------------------------------------------
   function automatic bit pick_d(input bit iv, input bit dv, input bit last_d);
`ifdef L2_ARB_RR_EN
      if (iv && dv) return !last_d;
      return dv;
`else
      if (iv) return dv;
      return 1'b1;
`endif
   endfunction

   bit           m_busy;
   bit           m_done;
   bit           m_own_d;
   bit           m_wr;
   logic [31:0]  m_addr;
   logic [255:0] m_wdata;
   logic [255:0] m_ird;
   logic [255:0] m_drd;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_busy  <= 1'b0;
         m_done  <= 1'b0;
         m_own_d <= 1'b1;
         m_wr    <= 1'b0;
         m_addr  <= '0;
         m_wdata <= '0;
         m_ird   <= '0;
         m_drd   <= '0;
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (m_busy) begin
         if (l2_resp) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
            if (m_own_d) m_drd <= l2_rdata;
            else         m_ird <= l2_rdata;
         end
      end else if (i_read || (d_read ^ d_write)) begin
         m_busy  <= 1'b1;
         m_own_d <= pick_d(i_read, d_read ^ d_write, m_own_d);
         m_wr    <= pick_d(i_read, d_read ^ d_write, m_own_d) && d_write;
         m_addr  <= (pick_d(i_read, d_read ^ d_write, m_own_d) ? d_address : i_address)
                    & 32'hFFFF_FFE0;
         if (pick_d(i_read, d_read ^ d_write, m_own_d) && d_write) m_wdata <= d_wdata;
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (rst) begin
         chk1("m_l2_read", l2_read, m_busy && !m_wr);
         chk1("m_l2_write", l2_write, m_busy && m_wr);
         chk1("m_i_resp", i_resp, m_done && !m_own_d);
         chk1("m_d_resp", d_resp, m_done && m_own_d);
         chk256("m_i_rdata", i_rdata, m_ird);
         chk256("m_d_rdata", d_rdata, m_drd);
         if (m_busy) chk32("m_l2_address", l2_address, m_addr);
         if (m_busy && m_wr) chk256("m_l2_wdata", l2_wdata, m_wdata);
         if (m_done) begin
            chk32("m_done_address", l2_address, 32'h0);
            chk256("m_done_wdata", l2_wdata, '0);
         end
      end
   end

   // L2 responder: random (or forced) latency counted from the first command cycle.
   initial begin : l2_responder
      int cyc;
      int lat;
      cyc      = 0;
      lat      = 1;
      l2_resp  = 1'b0;
      l2_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (rst && (l2_read || l2_write)) begin
            if (cyc == 0) lat = (force_lat > 0) ? force_lat : int'($urandom_range(1, 5));
            cyc++;
            l2_resp  = (cyc == lat);
            l2_rdata = use_fixed ? fixed_rdata : rand256();
         end else begin
            cyc      = 0;
            l2_resp  = 1'b0;
            l2_rdata = rand256();
         end
      end
   end

   task automatic wait_resp(input string name, output bit gi, output bit gd);
      gi = 1'b0;
      gd = 1'b0;
      for (int n = 0; n < 60 && !(gi || gd); n++) begin
         @(negedge clk);
         gi = i_resp;
         gd = d_resp;
      end
      checks++;
      if (!(gi || gd)) begin
         errors++;
         $display("FAIL %s: resp got none expected one within 60 cycles", name);
      end
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      bit         gi;
      bit         gd;
      logic [2:0] exp_d;
      int         ill_cnt;
      int         sel;

      rst       = 1'b0;
      i_read    = 1'b0;
      i_address = '0;
      d_read    = 1'b0;
      d_write   = 1'b0;
      d_address = '0;
      d_wdata   = '0;
      ill_cnt   = 0;

      // Reset values.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk1("rst_l2_read", l2_read, 1'b0);
      chk1("rst_l2_write", l2_write, 1'b0);
      chk32("rst_l2_address", l2_address, 32'h0);
      chk256("rst_l2_wdata", l2_wdata, '0);
      chk1("rst_i_resp", i_resp, 1'b0);
      chk1("rst_d_resp", d_resp, 1'b0);
      chk256("rst_i_rdata", i_rdata, '0);
      chk256("rst_d_rdata", d_rdata, '0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk1("idle_l2_read", l2_read, 1'b0);
      chk1("idle_l2_write", l2_write, 1'b0);

      // I read hit: grant in cycle 0, command + l2_resp in cycle 1, i_resp in cycle 2.
      @(posedge clk);
      #1;
      force_lat   = 1;
      use_fixed   = 1'b1;
      fixed_rdata = {32{8'hAA}};
      i_read      = 1'b1;
      i_address   = 32'h0000_104F;
      @(negedge clk);
      chk1("hit_c0_l2_read", l2_read, 1'b0);
      @(negedge clk);
      chk1("hit_c1_l2_read", l2_read, 1'b1);
      chk32("hit_c1_address", l2_address, 32'h0000_1040);
      @(negedge clk);
      chk1("hit_c2_i_resp", i_resp, 1'b1);
      chk1("hit_c2_d_resp", d_resp, 1'b0);
      chk256("hit_c2_i_rdata", i_rdata, {32{8'hAA}});
      chk1("hit_c2_l2_read", l2_read, 1'b0);
      @(posedge clk);
      #1;
      i_read    = 1'b0;
      use_fixed = 1'b0;
      @(negedge clk);
      chk1("hit_c3_i_resp", i_resp, 1'b0);
      chk256("hit_c3_i_rdata_hold", i_rdata, {32{8'hAA}});

      // D write miss, 10-cycle L2 latency; inputs scrambled mid-BUSY must not matter.
      @(posedge clk);
      #1;
      force_lat = 10;
      d_write   = 1'b1;
      d_address = 32'h8000_0020;
      d_wdata   = {64{4'h5}};
      @(negedge clk);
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         chk1($sformatf("wr_c%0d_l2_write", n), l2_write, 1'b1);
         chk1($sformatf("wr_c%0d_l2_read", n), l2_read, 1'b0);
         chk32($sformatf("wr_c%0d_address", n), l2_address, 32'h8000_0020);
         chk256($sformatf("wr_c%0d_wdata", n), l2_wdata, {64{4'h5}});
         chk1($sformatf("wr_c%0d_d_resp", n), d_resp, 1'b0);
         if (n == 3) begin
            d_address = 32'hDEAD_BEE0;
            d_wdata   = {64{4'hC}};
         end
      end
      @(negedge clk);
      chk1("wr_done_d_resp", d_resp, 1'b1);
      chk1("wr_done_l2_write", l2_write, 1'b0);
      chk1("wr_done_i_resp", i_resp, 1'b0);
      @(posedge clk);
      #1 d_write = 1'b0;
      @(negedge clk);
      chk1("wr_after_d_resp", d_resp, 1'b0);

      // Illegal D request alongside I read: only I is served, D never.
      @(posedge clk);
      #1;
      force_lat = 2;
      d_read    = 1'b1;
      d_write   = 1'b1;
      i_read    = 1'b1;
      i_address = 32'h0000_2000;
      wait_resp("illegal_resp", gi, gd);
      chk1("illegal_i_granted", gi, 1'b1);
      chk1("illegal_d_not_granted", gd, 1'b0);
      @(posedge clk);
      #1 i_read = 1'b0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         chk1($sformatf("illegal_hold%0d_l2_write", n), l2_write, 1'b0);
         chk1($sformatf("illegal_hold%0d_l2_read", n), l2_read, 1'b0);
      end
      @(posedge clk);
      #1;
      d_read  = 1'b0;
      d_write = 1'b0;

      // Three back-to-back simultaneous pairs (last owner is I at this point).
`ifdef L2_ARB_RR_EN
      exp_d = 3'b101;
`else
      exp_d = 3'b111;
`endif
      force_lat = 0;
      for (int r = 0; r < 3; r++) begin
         if (!i_read) begin
            i_read    = 1'b1;
            i_address = 32'h0001_0000 + 32'(r * 32);
         end
         if (!d_read) begin
            d_read    = 1'b1;
            d_address = 32'h0002_0000 + 32'(r * 32);
         end
         wait_resp($sformatf("pair%0d_resp", r), gi, gd);
         chk1($sformatf("pair%0d_d_granted", r), gd, exp_d[r]);
         @(posedge clk);
         #1;
         if (gd) d_read = 1'b0;
         if (gi) i_read = 1'b0;
      end
      i_read = 1'b0;
      d_read = 1'b0;
      repeat (8) @(posedge clk);

      // Async reset mid-BUSY drops the command before the next clock edge.
      #1;
      force_lat = 8;
      i_read    = 1'b1;
      i_address = 32'h0000_3000;
      repeat (3) @(negedge clk);
      chk1("arst_before_l2_read", l2_read, 1'b1);
      #1 rst = 1'b0;
      #1;
      chk1("arst_l2_read_dropped", l2_read, 1'b0);
      chk32("arst_l2_address", l2_address, 32'h0);
      chk256("arst_i_rdata", i_rdata, '0);
      i_read = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      force_lat = 3;
      i_read    = 1'b1;
      i_address = 32'h0000_4000;
      wait_resp("post_rst_resp", gi, gd);
      chk1("post_rst_i_granted", gi, 1'b1);
      @(posedge clk);
      #1 i_read = 1'b0;

      // Randomized traffic with protocol-following requesters.
      force_lat = 0;
      repeat (3000) begin
         @(posedge clk);
         #1;
         if (i_resp) begin
            i_read = 1'b0;
         end else if (!i_read) begin
            i_address = $urandom();
            if ($urandom_range(0, 3) == 0) i_read = 1'b1;
         end
         if (d_resp) begin
            d_read  = 1'b0;
            d_write = 1'b0;
         end else if (ill_cnt > 0) begin
            ill_cnt--;
            if (ill_cnt == 0) begin
               d_read  = 1'b0;
               d_write = 1'b0;
            end
         end else if (!d_read && !d_write) begin
            d_address = $urandom();
            d_wdata   = rand256();
            if ($urandom_range(0, 2) == 0) begin
               sel = int'($urandom_range(0, 9));
               if (sel == 0) begin
                  d_read  = 1'b1;
                  d_write = 1'b1;
                  ill_cnt = int'($urandom_range(1, 6));
               end else if (sel < 5) begin
                  d_read = 1'b1;
               end else begin
                  d_write = 1'b1;
               end
            end
         end
      end
      i_read  = 1'b0;
      d_read  = 1'b0;
      d_write = 1'b0;
      repeat (20) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/l2_arbiter.md
# l2_arbiter

Two-port arbiter that shares the single unified L2 cache between the L1 instruction cache and the L1 data cache. Each L1 miss or writeback is presented as a 256-bit cacheline read or write. The arbiter grants one requester at a time, forwards a registered copy of its command to the L2, and returns the L2 response and line data to the granted requester. It sits between the two L1 cache controllers and the L2 control/datapath pair.

## Interface
- No parameters. Line width is 256 bits and address width is 32 bits, both fixed via package constants.
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- i_read  in  1  I-cache line read request
- i_address  in  32  I-cache line address (bits [4:0] ignored)
- i_rdata  out  256  line data returned to I-cache
- i_resp  out  1  I-cache completion pulse
- d_read / d_write  in  1 / 1  D-cache line read / write request
- d_address  in  32  D-cache line address
- d_wdata  in  256  D-cache writeback line
- d_rdata  out  256  line data returned to D-cache
- d_resp  out  1  D-cache completion pulse
- l2_read / l2_write  out  1 / 1  command to L2
- l2_address  out  32  L2 line address
- l2_wdata  out  256  L2 write line
- l2_rdata  in  256  L2 read line
- l2_resp  in  1  L2 completion; may assert in the first command cycle (hit)

## Operation
- States: IDLE, BUSY, DONE. Grant register `owner` ∈ {I, D}.
- IDLE:
  - Sample valid requests: I valid = i_read; D valid = d_read XOR d_write.
  - d_read & d_write together is illegal and is not granted. It stays ignored while both are held.
  - On grant, latch owner, operation, address with bits [4:0] cleared, and wdata (D writes only), then go to BUSY.
- Arbitration is configurable, see Configuration.
- BUSY:
  - Drive l2_read/l2_write/l2_address/l2_wdata from the latched registers only. Requester inputs are not observed.
  - On l2_resp: latch l2_rdata into the owner's rdata register, then go to DONE.
- DONE:
  - Assert the owner's resp for exactly one cycle; the non-owner's resp stays 0.
  - L2 command outputs are 0.
  - Next state is IDLE.
- Requesters hold their request until they see resp, and drop it the cycle after. IDLE therefore never re-grants a completed request.
- The non-owner request stays pending, untouched, until it is granted.
- i_rdata/d_rdata hold their last latched value until the next completion for that port.

## Timing
- Reset values: state IDLE, owner D, all resp/l2_read/l2_write 0, l2_address 0, l2_wdata 0, both rdata 0.
- Reset mid-BUSY abandons the L2 command immediately. Because reset is asynchronous, l2_read and l2_write drop without waiting for a clock edge.
- Cycle timeline:
  - Request seen in IDLE at cycle 0.
  - L2 command active from cycle 1.
  - l2_resp at cycle k ≥ 1.
  - Requester resp at k+1.
  - IDLE at k+2, which is the earliest next grant.
- Minimum round trip is 3 cycles per transaction; a hit has k = 1.
- l2_read/l2_write are high only in BUSY and are never both high.
- A change of requester inputs during BUSY or DONE has no effect.

## Configuration
- `L2_ARB_RR_EN` defined: round-robin arbitration.
  - When both requesters are valid in IDLE, grant the one that is not the last owner.
  - With a single valid requester, grant it.
- Undefined: fixed priority, D before I.
  - Under continuous D traffic, I may starve; this is accepted.

## Structure
- The shared package `cache_types` holds:
  - `LINE_W` = 256 and `ADDR_W` = 32
  - the `arb_state_t` enum {IDLE, BUSY, DONE}
  - the `arb_owner_t` enum {OWN_I, OWN_D}
- One sub-module, `l2_arb_pick`: the combinational grant decision. Inputs: the two valid signals and the last owner. Outputs: grant-valid and the selected owner. The macro is applied only inside this sub-module.
- The top module holds the FSM, the latches and the output muxing.

## Test plan
- Reset: rst=0 at any state → all outputs as listed, state IDLE; release → idle with no L2 command.
- I read hit: i_read at 0x0000_1040, l2_resp in the first BUSY cycle with rdata=0xAA..AA → i_resp at cycle 2, i_rdata=0xAA..AA, d_resp stays 0.
- D write miss: d_write, address 0x8000_0020, wdata 0x55..55, l2_resp after 10 cycles → l2_write held 10 cycles with constant address and data, then d_resp for one cycle.
- Simultaneous requests from I and D:
  - With `L2_ARB_RR_EN`: grant order D, I, D across three back-to-back pairs.
  - Without it: D always first.
- Illegal D request: d_read=d_write=1 with i_read=1 → I granted, D never granted, no L2 write.
- Async reset asserted mid-BUSY → l2_read drops before the next clock edge; after release, a new request completes normally.
